matrix_mac_n: RTL and testbench

MATRIX_MAC_N -- requirements
Module: matrix_mac_n

---
 rtl/matrix_mac_n.sv | 181 ++++++++++++++++++
 tb/tb_matrix_mac_n.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mac_n.sv
// NxN matrix multiply-accumulate engine driven by a byte-wide command port.
// Commands execute once on change; results are read back a byte at a time.
module matrix_mac_n #(
  parameter int N      = 3,
  parameter int SIGNED = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out
);

  localparam int unsigned IW = (N > 2) ? 2 : 1;
  localparam int unsigned AW = 18;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  state_e state_q, state_d;

  logic [7:0]    cmd_q, cmd_prev_q, data_q;
  logic [7:0]    a_q [N][N];
  logic [7:0]    b_q [N][N];
  logic [AW-1:0] c_q [N][N];
  logic [IW-1:0] i_q, j_q, k_q, i_d, j_d, k_d;
  logic          err_q;
  logic [7:0]    uo_d;

  logic          exec, busy, done, in_rng, mac_en, mac_last;
  logic          ld_a, ld_b, start, rd, stat, clr, set_err;
  logic [3:0]    hi, lo;
  logic [IW-1:0] row, col;
  logic [AW-1:0] c_sel, mac_prod;
  logic          ext;

  function automatic logic [AW-1:0] widen(input logic [7:0] x);
    return (SIGNED != 0) ? {{(AW-8){x[7]}}, x} : {{(AW-8){1'b0}}, x};
  endfunction

  // Command decode: a command acts only on the edge after it first appears.
  always_comb begin
    hi      = cmd_q[7:4];
    lo      = cmd_q[3:0];
    row     = IW'(lo[3:2]);
    col     = IW'(lo[1:0]);
    in_rng  = ({1'b0, lo[3:2]} < 3'(N)) && ({1'b0, lo[1:0]} < 3'(N));
    exec    = ena && (cmd_q != cmd_prev_q);
    busy    = (state_q == S_BUSY);
    done    = (state_q == S_DONE);
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    start   = 1'b0;
    rd      = 1'b0;
    stat    = 1'b0;
    clr     = 1'b0;
    set_err = 1'b0;
    if (exec) begin
      case (hi)
        4'h1:                if (!busy && in_rng) ld_a  = 1'b1; else set_err = 1'b1;
        4'h2:                if (!busy && in_rng) ld_b  = 1'b1; else set_err = 1'b1;
        4'h3:                if (!busy && lo == 4'h0) start = 1'b1; else set_err = 1'b1;
        4'hA:                if (lo == 4'hA) clr = 1'b1; else set_err = 1'b1;
        4'hB:                if (lo != 4'hB) set_err = 1'b1;
        4'hC:                if (lo == 4'h0) stat = 1'b1; else set_err = 1'b1;
        4'hD, 4'hE, 4'hF:    if (!busy && in_rng) rd = 1'b1; else set_err = 1'b1;
        default:             set_err = 1'b1;
      endcase
    end
  end

  // Readback byte select; the top byte carries the accumulator's extension.
  always_comb begin
    c_sel = c_q[row][col];
    ext   = (SIGNED != 0) && c_sel[AW-1];
    uo_d  = uo_out;
    if (stat) begin
      uo_d = {busy, done, err_q, (SIGNED != 0), 2'b00, 2'(N - 1)};
    end else if (rd) begin
      case (hi)
        4'hD:    uo_d = c_sel[7:0];
        4'hE:    uo_d = c_sel[15:8];
        default: uo_d = {{6{ext}}, c_sel[AW-1:16]};
      endcase
    end
  end

  // One MAC per cycle, k innermost, then j, then i.
  always_comb begin
    mac_last = (i_q == LAST) && (j_q == LAST) && (k_q == LAST);
    mac_en   = ena && busy && !clr;
    mac_prod = widen(a_q[i_q][k_q]) * widen(b_q[k_q][j_q]);
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    if (k_q == LAST) begin
      k_d = '0;
      if (j_q == LAST) begin
        j_d = '0;
        i_d = (i_q == LAST) ? '0 : i_q + 1'b1;
      end else begin
        j_d = j_q + 1'b1;
      end
    end else begin
      k_d = k_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ena) begin
      if (clr)                                  state_d = S_IDLE;
      else if (start)                           state_d = S_BUSY;
      else if (busy && mac_last)                state_d = S_DONE;
      else if ((ld_a || ld_b) && done)          state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q      <= '0;
      cmd_prev_q <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      uo_out     <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
          c_q[r][c] <= '0;
        end
      end
    end else if (ena) begin
      cmd_q      <= uio_in;
      cmd_prev_q <= cmd_q;
      data_q     <= ui_in;
      uo_out     <= uo_d;
      if (clr) begin
        err_q <= 1'b0;
        i_q   <= '0;
        j_q   <= '0;
        k_q   <= '0;
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            a_q[r][c] <= '0;
            b_q[r][c] <= '0;
            c_q[r][c] <= '0;
          end
        end
      end else begin
        if (set_err) err_q <= 1'b1;
        if (ld_a) a_q[row][col] <= data_q;
        if (ld_b) b_q[row][col] <= data_q;
        if (start) begin
          i_q <= '0;
          j_q <= '0;
          k_q <= '0;
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
              c_q[r][c] <= '0;
            end
          end
        end else if (mac_en) begin
          c_q[i_q][j_q] <= c_q[i_q][j_q] + mac_prod;
          i_q           <= i_d;
          j_q           <= j_d;
          k_q           <= k_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_mac_n.sv
// Three configurations share one command stream; a matrix-level reference
// model predicts readback bytes, which a monitor checks as they appear.
module tb_matrix_mac_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo0, uo1, uo2;

  matrix_mac_n #(.N(3), .SIGNED(0)) u0 (.clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in), .uo_out(uo0));
  matrix_mac_n #(.N(4), .SIGNED(0)) u1 (.clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in), .uo_out(uo1));
  matrix_mac_n #(.N(2), .SIGNED(1)) u2 (.clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in), .uo_out(uo2));

  typedef struct {int inst; int e; int v; int cmd;} exp_t;
  exp_t sb[$];

  int ma [3][4][4];
  int mb [3][4][4];
  int mc [3][4][4];
  bit merr [3];
  bit mrun [3];
  int mst  [3];
  int m_uo [3];
  int last_sent;
  int ecyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  function automatic int np(input int k);
    return (k == 0) ? 3 : (k == 1) ? 4 : 2;
  endfunction

  function automatic bit sg(input int k);
    return (k == 2);
  endfunction

  function automatic int uo_of(input int k);
    return (k == 0) ? int'(uo0) : (k == 1) ? int'(uo1) : int'(uo2);
  endfunction

  function automatic int sv(input int k, input int v);
    return (sg(k) && v > 127) ? v - 256 : v;
  endfunction

  function automatic void chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%02h want 0x%02h", nm, act, exp);
  endfunction

  function automatic void model_clear(input int k);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[k][r][c] = 0; mb[k][r][c] = 0; mc[k][r][c] = 0;
      end
    merr[k] = 1'b0;
    mrun[k] = 1'b0;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      model_clear(k);
      m_uo[k] = 0;
      mst[k]  = 0;
    end
    last_sent = 0;
  endfunction

  function automatic void expect_byte(input int k, input int x, input int c, input int v);
    exp_t e;
    e.inst = k; e.e = x; e.v = v; e.cmd = c;
    sb.push_back(e);
    m_uo[k] = v;
  endfunction

  function automatic void multiply(input int k);
    int n, s;
    n = np(k);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int kk = 0; kk < n; kk++) s += sv(k, ma[k][i][kk]) * sv(k, mb[k][kk][j]);
        mc[k][i][j] = s;
      end
  endfunction

  // Effect of command c executing at enabled edge number x.
  function automatic void model_apply(input int c, input int d, input int x);
    if (c == last_sent) return;
    last_sent = c;
    for (int k = 0; k < 3; k++) begin
      int n, hi, lo, r, cc, v;
      bit bz, dn, rng;
      n   = np(k);
      bz  = mrun[k] && ((x - mst[k]) <= n * n * n);
      dn  = mrun[k] && !bz;
      hi  = c >> 4;
      lo  = c & 15;
      r   = lo >> 2;
      cc  = lo & 3;
      rng = (r < n) && (cc < n);
      case (hi)
        1, 2: if (bz || !rng) merr[k] = 1'b1;
              else begin
                if (hi == 1) ma[k][r][cc] = d; else mb[k][r][cc] = d;
                if (dn) mrun[k] = 1'b0;
              end
        3:    if (lo != 0 || bz) merr[k] = 1'b1;
              else begin multiply(k); mrun[k] = 1'b1; mst[k] = x; end
        10:   if (lo == 10) model_clear(k); else merr[k] = 1'b1;
        11:   if (lo != 11) merr[k] = 1'b1;
        12:   if (lo != 0) merr[k] = 1'b1;
              else expect_byte(k, x, c, (bz ? 128 : 0) + (dn ? 64 : 0) + (merr[k] ? 32 : 0)
                                        + (sg(k) ? 16 : 0) + (n - 1));
        13, 14, 15: if (bz || !rng) merr[k] = 1'b1;
              else begin
                v = mc[k][r][cc];
                expect_byte(k, x, c, (hi == 13) ? (v & 255) : (hi == 14) ? ((v >> 8) & 255)
                                                  : ((v >>> 16) & 255));
              end
        default: merr[k] = 1'b1;
      endcase
    end
  endfunction

  always @(posedge clk) if (ena && rst_n) ecyc <= ecyc + 1;

  // Monitor: compares each predicted byte once its execution edge has passed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].e <= ecyc) begin
        e = sb.pop_front();
        chk($sformatf("inst%0d cmd %02h", e.inst, e.cmd), uo_of(e.inst), e.v);
      end
    end
  end

  task automatic send(input logic [7:0] c, input logic [7:0] d);
    @(negedge clk);
    uio_in = c;
    ui_in  = d;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_apply(int'(c), int'(d), ecyc);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic check_hold(input string nm);
    for (int k = 0; k < 3; k++) chk($sformatf("%s inst%0d", nm, k), uo_of(k), m_uo[k]);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    uio_in = 8'h00;
    #1;
    model_reset();
    check_hold("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] g;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    model_reset();
    #1;
    check_hold("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    send(8'hC0, 8'h00);
    // Row 0 of A against column 0 of B.
    send(8'h10, 8'h01); send(8'h11, 8'h23); send(8'h12, 8'h45);
    send(8'h20, 8'hFE); send(8'h24, 8'h98); send(8'h28, 8'h32);
    send(8'h30, 8'h00);
    idle(70);
    send(8'hD0, 8'h00); send(8'hE0, 8'h00); send(8'hF0, 8'h00); send(8'hC0, 8'h00);
    send(8'hAA, 8'h00);
    check_hold("clr_hold");
    send(8'hC0, 8'h00);

    // Commands rejected while busy.
    send(8'h10, 8'h07); send(8'h20, 8'h09); send(8'h30, 8'h00);
    send(8'h11, 8'h55); send(8'h13, 8'h55); send(8'hD0, 8'h00); send(8'hC0, 8'h00);
    idle(70);
    send(8'hBB, 8'h00); send(8'hC0, 8'h00); send(8'hD0, 8'h00); send(8'hD1, 8'h00);

    // Held start executes once.
    send(8'hAA, 8'h00);
    send(8'h10, 8'h03); send(8'h20, 8'h05); send(8'h30, 8'h00);
    idle(40);
    send(8'hC0, 8'h00);
    idle(30);
    send(8'hD0, 8'h00);

    // Abort mid-compute.
    send(8'h30, 8'h00);
    idle(8);
    send(8'hAA, 8'h00);
    check_hold("abort_hold");
    send(8'hC0, 8'h00); send(8'hD0, 8'h00);

    // Enable gap during compute.
    send(8'h10, 8'h81); send(8'h20, 8'h7F); send(8'h30, 8'h00);
    idle(4);
    @(negedge clk); ena = 1'b0;
    repeat (9) @(negedge clk);
    ena = 1'b1;
    check_hold("ena_hold");
    send(8'hC0, 8'h00);
    idle(70);
    send(8'hD0, 8'h00); send(8'hE0, 8'h00); send(8'hF0, 8'h00);

    // Load after done keeps C and leaves DONE.
    send(8'h11, 8'h10);
    check_hold("load_hold");
    send(8'hC0, 8'h00); send(8'hD0, 8'h00); send(8'hE0, 8'h00);

    // Reset during compute, then a fresh job.
    send(8'h30, 8'h00);
    idle(5);
    pulse_reset();
    send(8'hC0, 8'h00);
    send(8'h10, 8'h09); send(8'h20, 8'h09); send(8'h30, 8'h00);
    idle(70);
    send(8'hD0, 8'h00); send(8'hE0, 8'h00);

    // All-ones operands hit the largest unsigned sums.
    send(8'hAA, 8'h00);
    for (int i = 0; i < 16; i++) begin
      send(8'(8'h10 + i), 8'hFF);
      send(8'(8'h20 + i), 8'hFF);
    end
    send(8'h30, 8'h00);
    idle(70);
    send(8'hDF, 8'h00); send(8'hEF, 8'h00); send(8'hFF, 8'h00);
    send(8'hD5, 8'h00); send(8'hE5, 8'h00); send(8'hF5, 8'h00);

    for (int rnd = 0; rnd < 24; rnd++) begin
      if (rnd % 4 == 0) send(8'hAA, 8'h00);
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 3) != 0) send(8'(8'h10 + i), 8'($urandom_range(0, 255)));
        if ($urandom_range(0, 3) != 0) send(8'(8'h20 + i), 8'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 3) == 0) begin
        g = 8'($urandom_range(1, 255));
        send(g, 8'($urandom_range(0, 255)));
      end
      send(8'h30, 8'h00);
      if ($urandom_range(0, 1) == 0) send(8'hD0, 8'h00);
      idle(70);
      for (int i = 0; i < 16; i++) begin
        g = 8'(8'hD0 + 8'h10 * $urandom_range(0, 2) + i);
        send(g, 8'h00);
      end
      send(8'hC0, 8'h00);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
